vregs_arb: RTL and testbench

Two-master Wishbone arbiter in front of the terminal register slave (cursor/VTCSR block). It lets master 0 (host CPU bus) and master 1 (local terminal engine: escape-sequence processor, keyboard-local mode) share that one slave port. Grant is round-robin and held for the whole `cyc` tenure. A per-transfer watchdog errors out transfers that are never acknowledged.

---
 rtl/vregs_arb.sv | 168 ++++++++++++++++
 tb/tb_vregs_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vregs_arb.sv
// Two-master Wishbone arbiter for the terminal register slave.
// Round-robin grant held for the whole cyc tenure, with a per-transfer ack watchdog.
module vregs_arb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int SW      = 2,
  parameter int TIMEOUT = 15,
  parameter int TOW     = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rstn_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic           last_reg, last_next;
  logic [TOW-1:0] cnt_reg, cnt_next;

  // Master-side buses gathered into arrays so both ports share one datapath.
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [1:0]    m_ack, m_err;
  logic [DW-1:0] m_rdat [2];

  assign m_cyc    = {m1_cyc_i, m0_cyc_i};
  assign m_stb    = {m1_stb_i, m0_stb_i};
  assign m_we     = {m1_we_i,  m0_we_i};
  assign m_adr[0] = m0_adr_i;
  assign m_adr[1] = m1_adr_i;
  assign m_dat[0] = m0_dat_i;
  assign m_dat[1] = m1_dat_i;
  assign m_sel[0] = m0_sel_i;
  assign m_sel[1] = m1_sel_i;

  logic       owned;
  logic       own_idx;
  logic [1:0] owner_hot;
  logic       wdog_hit;

  assign owned     = (state_reg != IDLE);
  assign own_idx   = (state_reg == OWN1);
  assign owner_hot = {state_reg == OWN1, state_reg == OWN0};
  assign gnt_o     = owner_hot;
  assign wdog_hit  = owned & s_stb_o & ~s_ack_i & (cnt_reg == TOW'(TIMEOUT));

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Only cyc steers the grant; on a tie the master that did not own last wins.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (m_cyc[0] && (!m_cyc[1] || last_reg)) begin
          state_next = OWN0;
        end else if (m_cyc[1]) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m_cyc[0]) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      OWN1: begin
        if (!m_cyc[1]) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The err cycle counts as the first cycle of the next window, so a stuck
  // strobe sees repeats exactly TIMEOUT cycles apart.
  always_comb begin
    cnt_next = '0;
    if (owned && m_cyc[own_idx] && s_stb_o && !s_ack_i) begin
      if (wdog_hit) begin
        cnt_next = TOW'(1);
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (owned) begin
      s_cyc_o = m_cyc[own_idx];
      s_stb_o = m_stb[own_idx];
      s_we_o  = m_we[own_idx];
      s_adr_o = m_adr[own_idx];
      s_dat_o = m_dat[own_idx];
      s_sel_o = m_sel[own_idx];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      assign m_ack[gi]  = owner_hot[gi] & s_ack_i;
      assign m_err[gi]  = owner_hot[gi] & wdog_hit;
      assign m_rdat[gi] = owner_hot[gi] ? s_dat_i : '0;
    end
  endgenerate

  assign m0_ack_o = m_ack[0];
  assign m0_err_o = m_err[0];
  assign m0_dat_o = m_rdat[0];
  assign m1_ack_o = m_ack[1];
  assign m1_err_o = m_err[1];
  assign m1_dat_o = m_rdat[1];

endmodule

// File: tb/tb_vregs_arb.sv
// Scoreboard bench for vregs_arb with a registered, alternating-ack register slave.
module tb_vregs_arb;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rstn_i = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [15:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [1:0]  m0_sel_i = 0;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [15:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [1:0]  m1_sel_i = 0;
  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [15:0] s_adr_o, s_dat_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  vregs_arb #(.AW(16), .DW(16), .SW(2), .TIMEOUT(15), .TOW(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_n = 0;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // Register slave: registered self-clearing ack, VTCSR (addr 2) resets to 0x0081.
  logic        ack_en = 1'b1;
  logic [15:0] regs [4];
  logic        sl_ack;
  logic [15:0] sl_rdat;
  logic        sl_take;
  logic [1:0]  sl_idx;
  assign sl_take = s_cyc_o & s_stb_o & ~sl_ack & ack_en;
  assign sl_idx  = s_adr_o[2:1];
  assign s_ack_i = sl_ack;
  assign s_dat_i = sl_rdat;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      sl_ack  <= 1'b0;
      sl_rdat <= 16'h0;
      regs[0] <= 16'h0000;
      regs[1] <= 16'h0081;
      regs[2] <= 16'h0000;
      regs[3] <= 16'h0000;
    end else begin
      sl_ack <= sl_take;
      if (sl_take) begin
        sl_rdat <= regs[sl_idx];
        if (s_we_o && s_sel_o[0]) regs[sl_idx][7:0]  <= s_dat_o[7:0];
        if (s_we_o && s_sel_o[1]) regs[sl_idx][15:8] <= s_dat_o[15:8];
      end
    end
  end

  typedef struct {
    int          m;
    bit          is_err;
    bit          chk_dat;
    logic [15:0] dat;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic push(input int m, input bit e, input bit cd, input logic [15:0] d, input int c);
    exp_t x;
    x.m = m; x.is_err = e; x.chk_dat = cd; x.dat = d; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc_n);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", name, act, cyc_n);
    end
  endtask

  // Monitor: every ack/err a master sees must match the next queued expectation.
  logic        mon_a, mon_e;
  logic [15:0] mon_d;
  exp_t        mon_x;
  always @(negedge wb_clk_i) begin
    for (int m = 0; m < 2; m++) begin
      mon_a = (m == 0) ? m0_ack_o : m1_ack_o;
      mon_e = (m == 0) ? m0_err_o : m1_err_o;
      mon_d = (m == 0) ? m0_dat_o : m1_dat_o;
      if (mon_a || mon_e) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected m%0d actual ack=%0b err=%0b required none (cycle %0d)",
                   m, mon_a, mon_e, cyc_n);
        end else begin
          mon_x = sb.pop_front();
          if (mon_x.m != m || mon_x.is_err != mon_e || mon_x.cyc != cyc_n ||
              (mon_x.chk_dat && mon_d !== mon_x.dat)) begin
            failures++;
            $display("FAIL sb_resp actual m=%0d err=%0b cyc=%0d dat=%h required m=%0d err=%0b cyc=%0d dat=%h",
                     m, mon_e, cyc_n, mon_d, mon_x.m, mon_x.is_err, mon_x.cyc, mon_x.dat);
          end else begin
            $display("ok   sb_resp m%0d %s dat=%h (cycle %0d)", m, mon_e ? "err" : "ack", mon_d, cyc_n);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  // Single transfer: hold cyc/stb until ack, drop them in the following cycle.
  task automatic xfer(input int m, input logic we, input logic [15:0] adr, input logic [15:0] dat);
    bit got;
    got = 0;
    set_m(m, 1, 1, we, adr, dat, 2'b11);
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk_i);
      if (ack_of(m)) begin
        got = 1;
        break;
      end
      step(1);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout m%0d actual=no_ack required=ack", m);
    end
    step(1);
    set_m(m, 0, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  int c0;

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    step(2);
    check("reset_slave_side", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, 0);
    check("reset_gnt", gnt_o, 2'b00);
    wb_rstn_i = 1'b1;
    step(1);

    // Reset pulse in the middle of an m0 transfer.
    set_m(0, 1, 1, 1, 16'h0004, 16'hAAAA, 2'b11);
    step(1);
    check("gnt_own0_before_rst", gnt_o, 2'b01);
    #2 wb_rstn_i = 1'b0;
    #1;
    check("rst_mid_slave_side", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, 0);
    check("rst_mid_master_side", {m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o, gnt_o}, 0);
    set_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step(1);
    wb_rstn_i = 1'b1;
    step(1);

    c0 = cyc_n;
    check("idle_in_request_cycle", gnt_o, 2'b00);
    push(0, 0, 1, 16'h0081, c0 + 2);
    fork
      xfer(0, 0, 16'h0002, 16'h0);
      begin step(1); check("gnt_after_reset", gnt_o, 2'b01); end
    join
    step(1);

    // Single master write/read.
    c0 = cyc_n;
    push(0, 0, 0, 16'h0, c0 + 2);
    fork
      xfer(0, 1, 16'h0000, 16'h0123);
      begin
        step(1);
        check("slave_sees_write", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o},
              {1'b1, 1'b1, 1'b1, 16'h0000, 16'h0123, 2'b11});
      end
    join
    step(1);
    c0 = cyc_n;
    push(0, 0, 1, 16'h0081, c0 + 2);
    xfer(0, 0, 16'h0002, 16'h0);
    step(1);
    c0 = cyc_n;
    push(0, 0, 1, 16'h0123, c0 + 2);
    xfer(0, 0, 16'h0000, 16'h0);
    step(1);

    // Contention right after reset: m0 first, one idle cycle, then m1.
    wb_rstn_i = 1'b0;
    step(1);
    wb_rstn_i = 1'b1;
    step(1);
    c0 = cyc_n;
    push(0, 0, 1, 16'h0000, c0 + 2);
    push(1, 0, 1, 16'h0081, c0 + 6);
    fork
      xfer(0, 0, 16'h0000, 16'h0);
      xfer(1, 0, 16'h0002, 16'h0);
      begin
        step(4);
        check("idle_between_tenures", {gnt_o, s_cyc_o}, 3'b000);
        step(1);
        check("gnt_m1_after_m0", gnt_o, 2'b10);
      end
    join
    step(1);

    // An m0-only tenure leaves last=0, so the next tie goes to m1.
    c0 = cyc_n;
    push(0, 0, 0, 16'h0, c0 + 2);
    xfer(0, 1, 16'h0004, 16'h5A5A);
    step(1);
    c0 = cyc_n;
    push(1, 0, 1, 16'h5A5A, c0 + 2);
    push(0, 0, 1, 16'h0081, c0 + 6);
    fork
      xfer(1, 0, 16'h0004, 16'h0);
      xfer(0, 0, 16'h0002, 16'h0);
      begin step(1); check("gnt_m1_first", gnt_o, 2'b10); end
    join
    step(1);

    // m1 holds stb for 6 slave cycles: acks on alternate cycles, no err.
    c0 = cyc_n;
    push(1, 0, 1, 16'h0081, c0 + 2);
    push(1, 0, 1, 16'h0081, c0 + 4);
    push(1, 0, 1, 16'h0081, c0 + 6);
    set_m(1, 1, 1, 0, 16'h0002, 16'h0, 2'b11);
    step(7);
    set_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step(1);

    // Watchdog with a dead slave: err in strobe cycles 16 and 31.
    ack_en = 1'b0;
    c0 = cyc_n;
    push(0, 1, 0, 16'h0, c0 + 16);
    push(0, 1, 0, 16'h0, c0 + 31);
    set_m(0, 1, 1, 0, 16'h0008, 16'h0, 2'b11);
    step(16);
    check("gnt_held_at_err1", gnt_o, 2'b01);
    step(16);
    check("gnt_held_after_err2", gnt_o, 2'b01);
    step(1);
    set_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    ack_en = 1'b1;
    step(2);

    // Isolation: m1 wiggles stb/we/adr while m0 owns.
    c0 = cyc_n;
    push(0, 0, 1, 16'h5A5A, c0 + 2);
    push(0, 0, 1, 16'h5A5A, c0 + 4);
    set_m(0, 1, 1, 0, 16'h0004, 16'h0, 2'b11);
    set_m(1, 0, 1, 1, 16'h00F0, 16'hFFFF, 2'b11);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("isolation", {s_adr_o, s_we_o, m1_ack_o, m1_err_o}, {16'h0004, 1'b0, 1'b0, 1'b0});
    end
    step(1);
    set_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    set_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step(3);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
